// File: rtl/mem_stage.sv
// mem_stage: M-stage memory access FSM with busy/done handshake, wait timeout and halt.
// Optional MEM_ALIGN_CHECK_EN rejects odd addresses with an errM pulse instead of issuing them.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        validM,
    input  logic        memRdM,
    input  logic        memWrtM,
    input  logic        haltM,
    input  logic [15:0] aluFinalM,
    input  logic [15:0] wrtDataM,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_busy,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic [15:0] memOutM,
    output logic        memValidM,
    output logic        stallM,
    output logic        haltedM,
    output logic        errM,
    output logic [7:0]  timeout_cnt
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, HALTED} state_t;
    state_t state, next;
    logic [15:0] addr_q, wdata_q;
    logic wr_q, access, misalign, accept, timeout;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = aluFinalM[0];
`else
    assign misalign = 1'b0;
`endif
    // haltM wins over a simultaneous load/store, so it is excluded from access
    assign access  = validM & (memRdM | memWrtM) & ~haltM;
    assign accept  = (state == IDLE) & access & ~misalign;
    assign timeout = (state == WAIT) & ~mem_done & (timeout_cnt == 8'hFF);
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (validM & haltM) ? HALTED : accept ? REQ : IDLE;
            REQ:     next = mem_busy ? REQ : WAIT;
            WAIT:    next = mem_done ? RESP : timeout ? IDLE : WAIT;
            RESP:    next = IDLE;
            HALTED:  next = HALTED;
            default: next = IDLE;
        endcase
    end
    assign mem_req   = state == REQ;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stallM    = accept | (state == REQ) | (state == WAIT);
    assign memValidM = (state == RESP) & ~wr_q;
    assign haltedM   = state == HALTED;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            memOutM     <= '0;
            timeout_cnt <= '0;
            errM        <= 1'b0;
        end else begin
            state <= next;
            errM  <= timeout | ((state == IDLE) & access & misalign);
            if (accept) begin
                addr_q  <= aluFinalM;
                wdata_q <= wrtDataM;
                wr_q    <= memWrtM;
            end
            if (state == WAIT)
                timeout_cnt <= (mem_done | timeout) ? 8'h00 : timeout_cnt + 8'd1;
            if ((state == WAIT) & mem_done & ~wr_q)
                memOutM <= mem_rdata;
            else if (timeout)
                memOutM <= 16'hFFFF;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table, randomized transactions and corner sequences for mem_stage.
module tb_mem_stage;
    logic clk = 0, rst = 1;
    logic validM = 0, memRdM = 0, memWrtM = 0, haltM = 0, mem_busy = 0, mem_done = 0;
    logic [15:0] aluFinalM = 0, wrtDataM = 0, mem_rdata = 0;
    logic mem_req, mem_wr, memValidM, stallM, haltedM, errM;
    logic [15:0] mem_addr, mem_wdata, memOutM;
    logic [7:0] timeout_cnt;
    int tests = 0, fails = 0;
    logic [15:0] exp_out = 0;
`ifdef MEM_ALIGN_CHECK_EN
    localparam logic [15:0] ODD_ADDR = 16'h0012;
`else
    localparam logic [15:0] ODD_ADDR = 16'h0013;
`endif
    typedef struct {
        logic rd, wr;
        logic [15:0] addr, data, rdata;
        int busy, delay;
    } rec_t;
    rec_t tbl[6];

    mem_stage dut (
        .clk(clk), .rst(rst), .validM(validM), .memRdM(memRdM), .memWrtM(memWrtM),
        .haltM(haltM), .aluFinalM(aluFinalM), .wrtDataM(wrtDataM), .mem_req(mem_req),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .memOutM(memOutM), .memValidM(memValidM),
        .stallM(stallM), .haltedM(haltedM), .errM(errM), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        validM = 0; memRdM = 0; memWrtM = 0; haltM = 0; mem_busy = 0; mem_done = 0;
    endtask

    task automatic all_zero(input string n);
        chk({n, "_req"}, mem_req, 0);
        chk({n, "_wr"}, mem_wr, 0);
        chk({n, "_addr"}, mem_addr, 0);
        chk({n, "_wdata"}, mem_wdata, 0);
        chk({n, "_out"}, memOutM, 0);
        chk({n, "_valid"}, memValidM, 0);
        chk({n, "_stall"}, stallM, 0);
        chk({n, "_halted"}, haltedM, 0);
        chk({n, "_err"}, errM, 0);
        chk({n, "_cnt"}, timeout_cnt, 0);
    endtask

    // Expected behaviour: 1 accept cycle, busy+1 request cycles, delay+1 wait cycles, 1 response cycle.
    task automatic run_access(input rec_t r);
        validM = 1; memRdM = r.rd; memWrtM = r.wr; haltM = 0;
        aluFinalM = r.addr; wrtDataM = r.data; mem_busy = 0; mem_done = 0;
        #1;
        chk("acc_stall", stallM, 1);
        chk("acc_req", mem_req, 0);
        tick;
        validM = 0; memRdM = 0; memWrtM = 0;
        aluFinalM = 16'($urandom); wrtDataM = 16'($urandom);
        for (int i = 0; i <= r.busy; i++) begin
            mem_busy = (i < r.busy);
            mem_done = 1'($urandom);
            #1;
            chk("req_req", mem_req, 1);
            chk("req_wr", mem_wr, r.wr);
            chk("req_addr", mem_addr, r.addr);
            if (r.wr) chk("req_wdata", mem_wdata, r.data);
            chk("req_stall", stallM, 1);
            chk("req_valid", memValidM, 0);
            tick;
        end
        for (int i = 0; i <= r.delay; i++) begin
            mem_busy = 1'($urandom);
            mem_done = (i == r.delay);
            mem_rdata = mem_done ? r.rdata : 16'($urandom);
            #1;
            chk("wait_req", mem_req, 0);
            chk("wait_stall", stallM, 1);
            chk("wait_cnt", timeout_cnt, i);
            tick;
        end
        if (!r.wr) exp_out = r.rdata;
        mem_done = 1'($urandom); mem_rdata = 16'($urandom);
        validM = 1; memRdM = 1; aluFinalM = 16'h0100;
        #1;
        chk("resp_valid", memValidM, !r.wr);
        chk("resp_out", memOutM, exp_out);
        chk("resp_stall", stallM, 0);
        chk("resp_cnt", timeout_cnt, 0);
        chk("resp_err", errM, 0);
        tick;
        idle_inputs();
        #1;
        chk("post_req", mem_req, 0);
        chk("post_valid", memValidM, 0);
        chk("post_out", memOutM, exp_out);
        tick;
    endtask

    initial begin
        tbl[0] = '{rd:1, wr:0, addr:16'h0010, data:16'h0000, rdata:16'hBEEF, busy:0, delay:0};
        tbl[1] = '{rd:0, wr:1, addr:16'h0020, data:16'h1234, rdata:16'h9999, busy:3, delay:0};
        tbl[2] = '{rd:1, wr:0, addr:16'h0040, data:16'h7777, rdata:16'h5A5A, busy:1, delay:3};
        tbl[3] = '{rd:1, wr:1, addr:16'h0044, data:16'hCAFE, rdata:16'h1111, busy:0, delay:1};
        tbl[4] = '{rd:1, wr:0, addr:ODD_ADDR, data:16'h0000, rdata:16'h0F0F, busy:2, delay:2};
        tbl[5] = '{rd:0, wr:1, addr:16'hFFFE, data:16'hFFFF, rdata:16'h2222, busy:0, delay:5};

        #2 rst = 0;
        #1 all_zero("rst");
        @(negedge clk);
        rst = 1;
        #1;
        for (int i = 0; i < 6; i++) run_access(tbl[i]);

        for (int n = 0; n < 20; n++) begin
            rec_t r;
            int k;
            k = $urandom_range(1, 3);
            r.rd = k[0]; r.wr = k[1];
            r.addr = 16'($urandom) & 16'hFFFE;
            r.data = 16'($urandom); r.rdata = 16'($urandom);
            r.busy = $urandom_range(0, 3); r.delay = $urandom_range(0, 6);
            run_access(r);
        end

        // load that never completes: wait counter runs to 0xFF then errors out
        validM = 1; memRdM = 1; aluFinalM = 16'h0030;
        tick;
        idle_inputs();
        tick;
        for (int i = 0; i < 256; i++) begin
            #1;
            chk("to_cnt", timeout_cnt, i);
            chk("to_stall", stallM, 1);
            chk("to_err", errM, 0);
            tick;
        end
        #1;
        chk("to_errpulse", errM, 1);
        chk("to_out", memOutM, 16'hFFFF);
        chk("to_stall_drop", stallM, 0);
        chk("to_cnt_clr", timeout_cnt, 0);
        chk("to_req", mem_req, 0);
        tick;
        chk("to_err_end", errM, 0);
        exp_out = 16'hFFFF;
        run_access(tbl[0]);

        // reset during WAIT abandons the access
        validM = 1; memRdM = 1; aluFinalM = 16'h0050;
        tick;
        idle_inputs();
        tick;
        #1 chk("rw_in_wait", stallM, 1);
        #2 rst = 0;
        #1 all_zero("rw");
        mem_done = 1; mem_rdata = 16'hDEAD;
        #1 rst = 1;
        tick;
        #1 all_zero("rw_after");
        tick;
        mem_done = 0;
        exp_out = 0;
        run_access(tbl[2]);

        // halt has priority over a simultaneous load
        validM = 1; haltM = 1; memRdM = 1; aluFinalM = 16'h0060;
        #1 chk("halt_stall", stallM, 0);
        tick;
        for (int i = 0; i < 5; i++) begin
            validM = 1; memRdM = 1'($urandom); memWrtM = 1'($urandom);
            haltM = 1'($urandom); mem_done = 1'($urandom);
            #1;
            chk("halted", haltedM, 1);
            chk("halt_req", mem_req, 0);
            chk("halt_stall2", stallM, 0);
            tick;
        end
        idle_inputs();
        #2 rst = 0;
        #1 all_zero("halt_rst");
        @(negedge clk);
        rst = 1;
        #1;
        exp_out = 0;
        run_access(tbl[1]);

`ifdef MEM_ALIGN_CHECK_EN
        validM = 1; memRdM = 1; aluFinalM = 16'h0011;
        #1 chk("al_stall", stallM, 0);
        tick;
        idle_inputs();
        #1;
        chk("al_err", errM, 1);
        chk("al_req", mem_req, 0);
        chk("al_stall2", stallM, 0);
        tick;
        chk("al_err_end", errM, 0);
        chk("al_req2", mem_req, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
